// File: rtl/narvie_inst_sequencer.sv
// Host-side instruction sequencer: packs 4 rx bytes into a word, issues it to the core for one
// cycle, lets the pipeline drain on NOPs, then returns the destination register as 4 tx bytes.
module narvie_inst_sequencer #(
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013,
  parameter int          DRAIN_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] cpu_inst,
  output logic [4:0]  dbg_rd_addr,
  input  logic [31:0] dbg_rd_data,
  output logic        busy
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_RX, S_ISSUE, S_DRAIN, S_READ, S_TX} state_t;

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [DW-1:0] drain_cnt;
  logic [31:0]   instr_q;
  logic [31:0]   result_q;
  logic          rx_fire, tx_fire;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    cpu_inst  = NOP_WORD;
    busy      = 1'b1;
    case (state)
      S_RX: begin
        rx_ready = 1'b1;
        busy     = 1'b0;
        if (rx_valid && byte_cnt == 2'd3) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        cpu_inst  = instr_q;
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = S_READ;
      end
      S_READ: state_nxt = S_TX;
      S_TX: begin
        tx_valid = 1'b1;
        tx_data  = result_q[{byte_cnt, 3'b000} +: 8];
        if (tx_ready && byte_cnt == 2'd3) state_nxt = S_RX;
      end
      default: state_nxt = S_RX;
    endcase
  end

  // byte_cnt is shared: rx word assembly in RX, tx byte select in TX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RX;
      byte_cnt    <= 2'd0;
      drain_cnt   <= '0;
      instr_q     <= 32'd0;
      result_q    <= 32'd0;
      dbg_rd_addr <= 5'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_RX: if (rx_fire) begin
          instr_q[{byte_cnt, 3'b000} +: 8] <= rx_data;
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_ISSUE: begin
          dbg_rd_addr <= instr_q[11:7];
          drain_cnt   <= '0;
        end
        S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        S_READ: begin
          result_q <= dbg_rd_data;
          byte_cnt <= 2'd0;
        end
        S_TX: if (tx_fire) byte_cnt <= byte_cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_narvie_inst_sequencer.sv
// Bench for narvie_inst_sequencer: a small RV32I core model serves the debug read port, and an
// architectural register model predicts every readback word.
module tb_narvie_inst_sequencer;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DRAIN = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] cpu_inst;
  logic [4:0]  dbg_rd_addr;
  logic [31:0] dbg_rd_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] cpu_regs [32];
  logic [31:0] exp_regs [32];
  logic        preload = 1'b0;

  narvie_inst_sequencer #(.NOP_WORD(NOP), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_inst(cpu_inst), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Core stand-in: executes whatever word appears on cpu_inst (addi/add write back, others don't)
  function automatic logic [31:0] rreg(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : cpu_regs[a];
  endfunction

  assign dbg_rd_data = rreg(dbg_rd_addr);

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) cpu_regs[i] <= exp_regs[i];
    end else if (cpu_inst[11:7] != 5'd0 && cpu_inst[14:12] == 3'b000) begin
      if (cpu_inst[6:0] == 7'h13)
        cpu_regs[cpu_inst[11:7]] <= rreg(cpu_inst[19:15]) + {{20{cpu_inst[31]}}, cpu_inst[31:20]};
      else if (cpu_inst[6:0] == 7'h33 && cpu_inst[31:25] == 7'h00)
        cpu_regs[cpu_inst[11:7]] <= rreg(cpu_inst[19:15]) + rreg(cpu_inst[24:20]);
    end
  end

  function automatic logic [31:0] encode(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [11:0] imm);
    case (kind)
      0:       return {imm, rs1, 3'b000, rd, 7'h13};                   // addi
      1:       return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};            // add
      default: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};  // sw
    endcase
  endfunction

  // Architectural reference: what register the sequencer reads back and what it should hold
  task automatic model(input int kind, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [11:0] imm, output logic [4:0] addr, output logic [31:0] val);
    logic [31:0] v;
    case (kind)
      0: v = exp_regs[rs1] + 32'($signed(imm));
      1: v = exp_regs[rs1] + exp_regs[rs2];
      default: v = 32'd0;
    endcase
    if (kind == 2) begin
      addr = imm[4:0];
      val  = exp_regs[imm[4:0]];
    end else begin
      addr = rd;
      val  = (rd == 5'd0) ? 32'd0 : v;
      if (rd != 5'd0) exp_regs[rd] = v;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    rst_n    = 1'b0;
    tick();
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_cpu_inst", cpu_inst, NOP);
    chk("rst_rd_addr", 32'(dbg_rd_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
  endtask

  // Returns just after the edge that accepted the 4th byte
  task automatic send_word(input logic [31:0] w, input int gap_max, input bit hold, input logic [7:0] hold_byte);
    int  g;
    int  budget;
    bit  acc;
    for (int i = 0; i < 4; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) begin
        rx_valid = 1'b0;
        repeat (g) tick();
      end
      rx_valid = 1'b1;
      rx_data  = w[8*i +: 8];
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 100) begin
        acc = rx_ready;
        tick();
        budget++;
      end
      chk("rx_accept", 32'(acc), 32'd1);
    end
    rx_valid = hold;
    rx_data  = hold ? hold_byte : 8'h00;
  endtask

  // Issue cycle, DRAIN NOP cycles, READ cycle; returns in the first TX cycle
  task automatic check_issue(input logic [31:0] w, input logic [4:0] addr);
    chk("issue_inst", cpu_inst, w);
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_rx_ready", 32'(rx_ready), 32'd0);
    for (int d = 0; d < DRAIN; d++) begin
      tick();
      chk("drain_inst", cpu_inst, NOP);
      chk("drain_tx_valid", 32'(tx_valid), 32'd0);
      chk("drain_rd_addr", 32'(dbg_rd_addr), 32'(addr));
      chk("drain_rx_ready", 32'(rx_ready), 32'd0);
    end
    tick();
    chk("read_tx_valid", 32'(tx_valid), 32'd0);
    chk("read_inst", cpu_inst, NOP);
    chk("read_busy", 32'(busy), 32'd1);
    tick();
  endtask

  task automatic collect(input logic [31:0] ev, input int nbytes, input int smin, input int smax);
    int s;
    for (int i = 0; i < nbytes; i++) begin
      s = int'($urandom_range(smax, smin));
      tx_ready = 1'b0;
      for (int k = 0; k < s; k++) begin
        chk("stall_tx_valid", 32'(tx_valid), 32'd1);
        chk("stall_tx_data", 32'(tx_data), 32'(ev[8*i +: 8]));
        chk("stall_rx_ready", 32'(rx_ready), 32'd0);
        tick();
      end
      tx_ready = 1'b1;
      chk("tx_valid", 32'(tx_valid), 32'd1);
      chk("tx_data", 32'(tx_data), 32'(ev[8*i +: 8]));
      chk("tx_rx_ready", 32'(rx_ready), 32'd0);
      chk("tx_cpu_inst", cpu_inst, NOP);
      tick();
    end
    if (nbytes == 4) begin
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_tx_valid", 32'(tx_valid), 32'd0);
      chk("done_rx_ready", 32'(rx_ready), 32'd1);
    end
  endtask

  task automatic run_txn(input int kind, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [11:0] imm, input int gap_max, input int smin, input int smax,
                         input bit hold, input logic [7:0] hold_byte);
    logic [31:0] w;
    logic [4:0]  addr;
    logic [31:0] val;
    w = encode(kind, rd, rs1, rs2, imm);
    model(kind, rd, rs1, rs2, imm, addr, val);
    send_word(w, gap_max, hold, hold_byte);
    check_issue(w, addr);
    collect(val, 4, smin, smax);
  endtask

  task automatic idle_no_tx(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_tx_valid", 32'(tx_valid), 32'd0);
      chk("idle_cpu_inst", cpu_inst, NOP);
    end
  endtask

  initial begin
    int          kind;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [4:0]  a;
    logic [31:0] v;
    logic [31:0] w;

    for (int i = 0; i < 32; i++) exp_regs[i] = $urandom;
    exp_regs[0] = 32'd0;
    preload = 1'b1;
    tick();
    preload = 1'b0;
    do_reset();

    // addi x1,x0,5 with a ready sink, then with 3-cycle stalls per byte
    run_txn(0, 5'd1, 5'd0, 5'd0, 12'd5, 0, 0, 0, 1'b0, 8'h00);
    run_txn(0, 5'd1, 5'd0, 5'd0, 12'd5, 0, 3, 3, 1'b0, 8'h00);

    // partial word dropped by reset
    rx_valid = 1'b1; rx_data = 8'hAA; tick();
    rx_data = 8'hBB; tick();
    rx_valid = 1'b0;
    do_reset();
    run_txn(0, 5'd2, 5'd0, 5'd0, 12'd10, 0, 0, 0, 1'b0, 8'h00);

    // canonical NOP: rd = x0
    run_txn(0, 5'd0, 5'd0, 5'd0, 12'd0, 0, 0, 0, 1'b0, 8'h00);

    // back-to-back with rx_valid held high across the whole first transaction
    run_txn(0, 5'd1, 5'd0, 5'd0, 12'd5, 0, 0, 0, 1'b1, 8'h33);
    run_txn(1, 5'd2, 5'd1, 5'd1, 12'd0, 0, 0, 0, 1'b0, 8'h00);

    // reset during DRAIN
    w = encode(0, 5'd3, 5'd0, 5'd0, 12'd7);
    model(0, 5'd3, 5'd0, 5'd0, 12'd7, a, v);
    send_word(w, 0, 1'b0, 8'h00);
    tick(); tick();
    do_reset();
    idle_no_tx(10);

    // reset during TX after two bytes
    w = encode(0, 5'd4, 5'd3, 5'd0, 12'hFFF);
    model(0, 5'd4, 5'd3, 5'd0, 12'hFFF, a, v);
    send_word(w, 0, 1'b0, 8'h00);
    check_issue(w, a);
    collect(v, 2, 0, 1);
    do_reset();
    idle_no_tx(6);

    // randomized mix of addi/add/sw with rx gaps and tx stalls
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(2, 0));
      rd   = ($urandom_range(4, 0) == 0) ? 5'd0 : 5'($urandom);
      rs1  = 5'($urandom);
      rs2  = 5'($urandom);
      imm  = 12'($urandom);
      run_txn(kind, rd, rs1, rs2, imm, 2, 0, 3, 1'b0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
